// File: rtl/tetris_pkg.sv
// Shared types for the score display: BCD digit type, converter FSM states
// and the active-low 7-segment glyph lookup.
package tetris_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} dd_state_t;

    localparam int BIN_W = 16;
    localparam int BCD_W = 20;

    function automatic logic [7:0] seg7_decode(input bcd_digit_t d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hBF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/score_bcd_display_bin2bcd_serial.sv
// Serial double-dabble converter: 16-bit binary to 5 BCD digits, one
// add-3/shift step per clock.
module bin2bcd_serial
    import tetris_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_W-1:0]     bcd
);

    dd_state_t                   r_state;
    dd_state_t                   w_next;
    logic [BCD_W+BIN_W-1:0]      r_sreg;
    logic [3:0]                  r_ctr;
    logic [BCD_W-1:0]            r_bcd;
    logic [BCD_W+BIN_W-1:0]      w_shifted;

    function automatic logic [BCD_W+BIN_W-1:0] dabble_step(input logic [BCD_W+BIN_W-1:0] s);
        logic [BCD_W+BIN_W-1:0] t;
        t = s;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (t[BIN_W+4*i +: 4] >= 4'd5)
                t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
        end
        return {t[BCD_W+BIN_W-2:0], 1'b0};
    endfunction

    assign w_shifted = dabble_step(r_sreg);
    assign bcd       = r_bcd;

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:  if (start) w_next = LOAD;
            LOAD:  begin
                busy   = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_ctr == 4'd15) w_next = DONE;
            end
            DONE:  begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand is captured on the IDLE->LOAD edge, the same edge on which the
    // top records it as the last converted value, so the two never disagree.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_ctr   <= '0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE:  if (start) r_sreg <= {{BCD_W{1'b0}}, bin};
                LOAD:  r_ctr <= '0;
                SHIFT: begin
                    r_sreg <= w_shifted;
                    r_ctr  <= r_ctr + 4'd1;
                    if (r_ctr == 4'd15) r_bcd <= w_shifted[BCD_W+BIN_W-1:BIN_W];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/score_bcd_display.sv
// Score display: synchronises the core's score/game_over, converts the score
// to BCD and drives a 4-digit multiplexed 7-segment display with blink.
module score_bcd_display
    import tetris_pkg::*;
#(
    parameter int SCAN_DIV  = 50_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int SYNC_LEN  = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [BIN_W-1:0]  score,
    input  logic              game_over,
    output logic [BCD_W-1:0]  bcd_out,
    output logic              bcd_valid,
    output logic              busy,
    output logic [7:0]        hex_seg,
    output logic [3:0]        hex_grid
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int RUN_W   = $clog2(SYNC_LEN + 1);

    logic [BIN_W-1:0]   r_score_s1, r_score_s2, r_score_prev, r_score_acc, r_last_bin;
    logic [RUN_W-1:0]   r_run;
    logic [RUN_W:0]     w_run_now;
    logic               r_go_s1, r_go_s2;
    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic               w_start, w_busy, w_done;
    logic [BCD_W-1:0]   w_bcd;
    bcd_digit_t         w_digit;
    logic               w_blank;

    // Run length of identical synchronised samples, counting the current one.
    always_comb begin
        w_run_now = (RUN_W+1)'(1);
        if (r_score_s2 == r_score_prev)
            w_run_now = {1'b0, r_run} + (RUN_W+1)'(1);
    end

    assign w_start = (r_score_acc != r_last_bin);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_score_s1   <= '0;
            r_score_s2   <= '0;
            r_score_prev <= '0;
            r_run        <= '0;
            r_score_acc  <= '0;
            r_last_bin   <= '0;
            r_go_s1      <= 1'b0;
            r_go_s2      <= 1'b0;
        end else begin
            r_score_s1   <= score;
            r_score_s2   <= r_score_s1;
            r_score_prev <= r_score_s2;
            r_go_s1      <= game_over;
            r_go_s2      <= r_go_s1;
            r_run        <= (w_run_now > (RUN_W+1)'(SYNC_LEN)) ? RUN_W'(SYNC_LEN)
                                                              : w_run_now[RUN_W-1:0];
            if (w_run_now >= (RUN_W+1)'(SYNC_LEN))
                r_score_acc <= r_score_s2;
            if (w_start && !w_busy && !w_done)
                r_last_bin <= r_score_acc;
        end
    end

    bin2bcd_serial u_conv (
        .Clk   (Clk),
        .Reset (Reset),
        .start (w_start),
        .bin   (r_score_acc),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    assign bcd_out   = w_bcd;
    assign bcd_valid = w_done;
    assign busy      = w_busy;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_scan_cnt  <= '0;
            r_idx       <= 2'd0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
            if (!r_go_s2) begin
                r_blink_cnt <= '0;
                r_blink_on  <= 1'b1;
            end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    // A digit is a leading zero when it and every higher shown digit are 0
    // and the hidden fifth digit is 0 as well.
    always_comb begin
        w_digit = bcd_out[{r_idx, 2'b00} +: 4];
        w_blank = (r_idx != 2'd0) && (bcd_out[19:16] == 4'd0)
                  && ((bcd_out[15:0] >> {r_idx, 2'b00}) == 16'd0);
        hex_seg = w_blank ? 8'hFF : seg7_decode(w_digit);
        if ((r_idx == 2'd3) && (bcd_out[19:16] != 4'd0))
            hex_seg[7] = 1'b0;
        hex_grid = r_blink_on ? ~(4'b0001 << r_idx) : 4'hF;
    end

endmodule

// File: tb/tb_score_bcd_display.sv
// Bench for score_bcd_display: directed and random scores checked against an
// arithmetic BCD/display model; blink and mid-conversion reset scenarios.
module tb_score_bcd_display;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] score = 16'd0;
    logic        game_over = 1'b0;
    logic [19:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic [7:0]  hex_seg;
    logic [3:0]  hex_grid;

    int checks   = 0;
    int failures = 0;
    int tb_cyc   = 0;
    int n_valid  = 0;
    int disp     = 0;

    logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 Clk = ~Clk;

    score_bcd_display #(.SCAN_DIV(4), .BLINK_DIV(16), .SYNC_LEN(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .score     (score),
        .game_over (game_over),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .hex_seg   (hex_seg),
        .hex_grid  (hex_grid)
    );

    always @(posedge Clk) tb_cyc <= Reset ? 0 : tb_cyc + 1;
    always @(negedge Clk) if (bcd_valid === 1'b1) n_valid <= n_valid + 1;

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int idx);
        logic [7:0] s;
        s = GLYPH[(v / p10(idx)) % 10];
        if (idx > 0 && v < p10(idx)) s = 8'hFF;
        if (idx == 3 && v >= 10000) s[7] = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] exp_grid(input logic on);
        int idx;
        idx = (tb_cyc / 4) % 4;
        return on ? ~(4'b0001 << idx) : 4'hF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_display(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            chk("grid", 32'(hex_grid), 32'(exp_grid(1'b1)));
            chk("seg", 32'(hex_seg), 32'(exp_seg(v, (tb_cyc / 4) % 4)));
            @(negedge Clk);
        end
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge Clk);
            if (bcd_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (busy === 1'b1) break;
        end
        chk("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic convert(input int v);
        int n;
        score = 16'(v);
        wait_valid(n);
        chk("latency", n, 22);
        chk("bcd", 32'(bcd_out), 32'(to_bcd(v)));
        disp = v;
    endtask

    initial begin
        int v, n;
        logic off;

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_valid", 32'(bcd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grid", 32'(hex_grid), 32'hE);
        chk("rst_seg", 32'(hex_seg), 32'hC0);
        check_display(0, 16);
        chk("no_valid_idle", n_valid, 0);

        convert(1234);
        check_display(1234, 16);
        convert(65535);
        check_display(65535, 16);
        convert(10000);
        check_display(10000, 16);
        convert(9);
        check_display(9, 16);

        for (int i = 0; i < 6; i++) begin
            v = (disp + 1 + int'($urandom_range(0, 65534))) % 65536;
            convert(v);
            check_display(v, 8);
        end

        convert(3);
        score = 16'd7;
        wait_busy();
        repeat (5) @(negedge Clk);
        score = 16'd9;
        wait_valid(n);
        chk("first_bcd", 32'(bcd_out), 32'(to_bcd(7)));
        wait_valid(n);
        chk("second_gap", n, 19);
        chk("second_bcd", 32'(bcd_out), 32'(to_bcd(9)));
        disp = 9;
        check_display(9, 16);

        game_over = 1'b1;
        for (int k = 1; k <= 56; k++) begin
            @(negedge Clk);
            off = (k >= 2) && ((((k - 2) / 16) % 2) == 1);
            chk("blink_grid", 32'(hex_grid), 32'(exp_grid(!off)));
            chk("blink_seg", 32'(hex_seg), 32'(exp_seg(disp, (tb_cyc / 4) % 4)));
        end
        game_over = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge Clk);
            off = (j <= 2) && ((((56 + j - 2) / 16) % 2) == 1);
            chk("release_grid", 32'(hex_grid), 32'(exp_grid(!off)));
        end

        score = 16'd4321;
        wait_busy();
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bcd", 32'(bcd_out), 32'd0);
        chk("midrst_valid", 32'(bcd_valid), 32'd0);
        chk("midrst_grid", 32'(hex_grid), 32'hE);
        Reset = 1'b0;
        disp = 0;
        check_display(0, 4);
        wait_valid(n);
        chk("post_rst_latency", n, 18);
        chk("post_rst_bcd", 32'(bcd_out), 32'(to_bcd(4321)));
        disp = 4321;
        check_display(4321, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
